// File: rtl/lane_seq_pkg.sv
// Shared types and helpers for the lane seed sequencer.
// Lane word shape, FSM states, Galois LFSR step.
package lane_seq_pkg;

  typedef logic [0:0][0:1][3:0] lane_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  localparam logic [15:0] DEFAULT_TAP = 16'hB400;

  // Right-shifting Galois step: shift out bit 0, fold it back through the tap mask.
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s,
    input logic [15:0] tap
  );
    return (s >> 1) ^ (s[0] ? tap : 16'h0000);
  endfunction

endpackage

// File: rtl/galois_lfsr16.sv
// 16-bit Galois LFSR, one per lane.
// Ports: clk, rst (sync high), load/load_val, step, state.
module galois_lfsr16
  import lane_seq_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAP  = DEFAULT_TAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= lfsr_step(state, TAP);
    end
  end

endmodule

// File: rtl/lane_seed_sequencer.sv
// Two-lane seeded stimulus source: bursts of LFSR words over valid/ready.
// Ports: start/len/abort, reseed/seed_a/seed_b, out_*, busy, done, checksum.
module lane_seed_sequencer
  import lane_seq_pkg::*;
#(
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D2B,
  parameter logic [15:0] TAP    = DEFAULT_TAP,
  parameter int          LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             reseed,
  input  logic [15:0]      seed_a,
  input  logic [15:0]      seed_b,
  output logic             out_valid,
  input  logic             out_ready,
  output lane_word_t       out_word [1:2],
  output logic             busy,
  output logic             done,
  output logic [15:0]      checksum
);

  seq_state_t       state_q;
  logic [LEN_W-1:0] rem_q;
  logic             valid_q;
  logic             done_q;
  logic [15:0]      cs_q;
  lane_word_t       word_q [1:2];

  logic [15:0] lfsr_a, lfsr_b;
  logic [15:0] step_a_d, step_b_d;
  logic [15:0] seed_a_d, seed_b_d;
  logic        fire, load, adv;
  logic        unused_hi;

  assign fire = valid_q && out_ready;
  assign load = (state_q == IDLE) && reseed;
  assign adv  = (state_q == RUN) && fire && !abort;

  // An all-zero state would lock the LFSR, so substitute the reset seed.
  assign seed_a_d = (seed_a == 16'h0000) ? SEED_A : seed_a;
  assign seed_b_d = (seed_b == 16'h0000) ? SEED_B : seed_b;

  // Next LFSR value, so the following word can be registered on the fire edge.
  assign step_a_d  = lfsr_step(lfsr_a, TAP);
  assign step_b_d  = lfsr_step(lfsr_b, TAP);
  assign unused_hi = ^{step_a_d[15:8], step_b_d[15:8]};

  galois_lfsr16 #(.SEED(SEED_A), .TAP(TAP)) u_lfsr_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (seed_a_d),
    .step     (adv),
    .state    (lfsr_a)
  );

  galois_lfsr16 #(.SEED(SEED_B), .TAP(TAP)) u_lfsr_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (seed_b_d),
    .step     (adv),
    .state    (lfsr_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= '0;
      word_q[1] <= '0;
      word_q[2] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // reseed wins over start in the same cycle
          if (!reseed && start && len != '0) begin
            state_q   <= RUN;
            rem_q     <= len;
            cs_q      <= '0;
            valid_q   <= 1'b1;
            word_q[1] <= lfsr_a[7:0];
            word_q[2] <= lfsr_b[7:0];
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rem_q   <= '0;
          end else if (fire) begin
            cs_q  <= cs_q ^ {word_q[1], word_q[2]};
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              word_q[1] <= step_a_d[7:0];
              word_q[2] <= step_b_d[7:0];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid   = valid_q;
  assign out_word[1] = word_q[1];
  assign out_word[2] = word_q[2];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign checksum    = cs_q;

endmodule
